// File: rtl/host_load_ctrl.sv
// Device end of the host init/start/load/result protocol: weight and feature loading, compute kick, result drain.
// Optional build macro HOST_IF_PERF_EN adds the perf_cycles output (first weight beat to last result beat).
module host_load_ctrl #(
    parameter int DW         = 16,
    parameter int LAYER_N    = 8,
    parameter int MAT_N      = 16,
    parameter int START_SKIP = 2,
    parameter int WADDR_W    = 10,
    parameter int FADDR_W    = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_valid,
    output logic                 init_ready,
    input  logic                 start_ready,
    output logic                 start_valid,
    output logic                 load_ready,
    input  logic [2*DW-1:0]      load_payload,
    output logic                 result_valid,
    output logic [2*DW-1:0]      result_payload,
    output logic                 w_wr_en,
    output logic [WADDR_W-1:0]   w_wr_addr,
    output logic [2*DW-1:0]      w_wr_data,
    output logic                 f_wr_en,
    output logic [FADDR_W-1:0]   f_wr_addr,
    output logic [2*DW-1:0]      f_wr_data,
    output logic                 comp_start,
    input  logic                 comp_done,
    output logic                 r_rd_en,
    output logic [FADDR_W-1:0]   r_rd_addr,
    input  logic [2*DW-1:0]      r_rd_data
`ifdef HOST_IF_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam int SKIP_W = (START_SKIP > 1) ? $clog2(START_SKIP) : 1;
    localparam logic [WADDR_W-1:0] W_LAST    = WADDR_W'(LAYER_N * MAT_N * MAT_N / 2 - 1);
    localparam logic [FADDR_W-1:0] F_LAST    = FADDR_W'(MAT_N * MAT_N / 2 - 1);
    localparam logic [SKIP_W-1:0]  SKIP_LAST = SKIP_W'(START_SKIP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_READY, S_SKIP, S_LOAD, S_COMPUTE, S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [WADDR_W-1:0]  wcnt_q, wcnt_d;
    logic [FADDR_W-1:0]  fcnt_q, fcnt_d;
    logic [FADDR_W-1:0]  rcnt_q, rcnt_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic                wloaded_q, wloaded_d;
    logic                tail_q, tail_d;
    logic                start_ready_q, start_ready_d;
    logic                comp_start_q, comp_start_d;
    logic                result_valid_q, result_valid_d;
    logic [2*DW-1:0]     result_payload_q, result_payload_d;

    always_comb begin
        // NOTE: every next-state value and output gets a default first, so no branch can infer a latch.
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        fcnt_d        = fcnt_q;
        rcnt_d        = rcnt_q;
        skip_d        = skip_q;
        wloaded_d     = wloaded_q;
        tail_d        = tail_q;
        start_ready_d = start_ready;
        comp_start_d  = 1'b0;
        init_ready    = 1'b0;
        start_valid   = 1'b0;
        load_ready    = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_addr     = wcnt_q;
        w_wr_data     = load_payload;
        f_wr_en       = 1'b0;
        f_wr_addr     = fcnt_q;
        f_wr_data     = load_payload;
        r_rd_en       = 1'b0;
        r_rd_addr     = rcnt_q;

        case (state_q)
            S_IDLE: begin
                init_ready = 1'b1;
                if (init_valid) begin
                    state_d   = S_INIT;
                    wcnt_d    = '0;
                    wloaded_d = 1'b0;
                end
            end
            S_INIT: begin
                load_ready = 1'b1;
                if (init_valid) begin
                    w_wr_en = 1'b1;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wcnt_q == W_LAST) begin
                        wloaded_d = 1'b1;
                        state_d   = S_READY;
                    end
                end
            end
            S_READY: begin
                start_valid = 1'b1;
                init_ready  = 1'b1;
                if (init_valid) begin
                    state_d   = S_INIT;
                    wcnt_d    = '0;
                    wloaded_d = 1'b0;
                end else if (start_ready && !start_ready_q && wloaded_q) begin
                    state_d = S_SKIP;
                    skip_d  = '0;
                end
            end
            S_SKIP: begin
                // Host preamble beats: nothing is consumed here.
                skip_d = skip_q + 1'b1;
                if (skip_q == SKIP_LAST) begin
                    state_d = S_LOAD;
                    fcnt_d  = '0;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (start_ready) begin
                    f_wr_en = 1'b1;
                    fcnt_d  = fcnt_q + 1'b1;
                    if (fcnt_q == F_LAST) begin
                        state_d      = S_COMPUTE;
                        comp_start_d = 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (comp_done) begin
                    state_d = S_DRAIN;
                    rcnt_d  = '0;
                    tail_d  = 1'b0;
                end
            end
            S_DRAIN: begin
                // tail_q marks the extra cycle in which the final registered beat is on the bus.
                if (!tail_q) begin
                    r_rd_en = 1'b1;
                    rcnt_d  = rcnt_q + 1'b1;
                    if (rcnt_q == F_LAST) tail_d = 1'b1;
                end else begin
                    state_d = S_READY;
                    tail_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        result_valid_d   = r_rd_en;
        result_payload_d = r_rd_en ? r_rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            wcnt_q           <= '0;
            fcnt_q           <= '0;
            rcnt_q           <= '0;
            skip_q           <= '0;
            wloaded_q        <= 1'b0;
            tail_q           <= 1'b0;
            start_ready_q    <= 1'b0;
            comp_start_q     <= 1'b0;
            result_valid_q   <= 1'b0;
            result_payload_q <= '0;
        end else begin
            state_q          <= state_d;
            wcnt_q           <= wcnt_d;
            fcnt_q           <= fcnt_d;
            rcnt_q           <= rcnt_d;
            skip_q           <= skip_d;
            wloaded_q        <= wloaded_d;
            tail_q           <= tail_d;
            start_ready_q    <= start_ready_d;
            comp_start_q     <= comp_start_d;
            result_valid_q   <= result_valid_d;
            result_payload_q <= result_payload_d;
        end
    end

    assign comp_start     = comp_start_q;
    assign result_valid   = result_valid_q;
    assign result_payload = result_payload_q;

`ifdef HOST_IF_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic        perf_run_q, perf_run_d;
    logic        perf_arm_q, perf_arm_d;

    // Armed by an IDLE->INIT entry, restarted on its first accepted beat, frozen after the last result beat.
    always_comb begin
        perf_cycles_d = perf_run_q ? perf_cycles_q + 32'd1 : perf_cycles_q;
        perf_run_d    = perf_run_q;
        perf_arm_d    = perf_arm_q;
        if (state_q == S_IDLE && init_valid) perf_arm_d = 1'b1;
        if (state_q == S_INIT && init_valid && perf_arm_q) begin
            perf_cycles_d = '0;
            perf_run_d    = 1'b1;
            perf_arm_d    = 1'b0;
        end
        if (state_q == S_DRAIN && tail_q) perf_run_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_run_q    <= 1'b0;
            perf_arm_q    <= 1'b0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_run_q    <= perf_run_d;
            perf_arm_q    <= perf_arm_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
`else
    // Performance counter not built.
`endif

endmodule

// File: tb/tb_host_load_ctrl.sv
// Self-checking bench for host_load_ctrl: scoreboard queues for weight, feature and result traffic.
// Builds with or without HOST_IF_PERF_EN.
module tb_host_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        init_valid;
    logic        init_ready;
    logic        start_ready;
    logic        start_valid;
    logic        load_ready;
    logic [31:0] load_payload;
    logic        result_valid;
    logic [31:0] result_payload;
    logic        w_wr_en;
    logic [9:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic        f_wr_en;
    logic [6:0]  f_wr_addr;
    logic [31:0] f_wr_data;
    logic        comp_start;
    logic        comp_done;
    logic        r_rd_en;
    logic [6:0]  r_rd_addr;
    logic [31:0] r_rd_data;
`ifdef HOST_IF_PERF_EN
    logic [31:0] perf_cycles;
`endif

    host_load_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_valid     (init_valid),
        .init_ready     (init_ready),
        .start_ready    (start_ready),
        .start_valid    (start_valid),
        .load_ready     (load_ready),
        .load_payload   (load_payload),
        .result_valid   (result_valid),
        .result_payload (result_payload),
        .w_wr_en        (w_wr_en),
        .w_wr_addr      (w_wr_addr),
        .w_wr_data      (w_wr_data),
        .f_wr_en        (f_wr_en),
        .f_wr_addr      (f_wr_addr),
        .f_wr_data      (f_wr_data),
        .comp_start     (comp_start),
        .comp_done      (comp_done),
        .r_rd_en        (r_rd_en),
        .r_rd_addr      (r_rd_addr),
        .r_rd_data      (r_rd_data)
`ifdef HOST_IF_PERF_EN
        ,
        .perf_cycles    (perf_cycles)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] res_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          w_wr_total   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory model: combinational read of addr*3.
    assign r_rd_data = 32'(r_rd_addr) * 32'd3;

    always @(posedge clk) if (rst_n && w_wr_en) w_wr_total++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] feat_beat(input int b);
        int r = b / 16;
        int c = b % 16;
        logic [15:0] hi = 16'((2 * r + 1) * 16 + c);
        logic [15:0] lo = 16'((2 * r) * 16 + c);
        return {hi, lo};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; init_valid = 1'b0; start_ready = 1'b0; load_payload = '0; comp_done = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        tests_run++;
        if ({start_valid, load_ready, result_valid, comp_start, w_wr_en, f_wr_en, r_rd_en} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {start_valid, load_ready, result_valid, comp_start, w_wr_en, f_wr_en, r_rd_en});
        end
        tests_run++;
        if (result_payload !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_payload: got %h expected 0", result_payload);
        end
`ifdef HOST_IF_PERF_EN
        tests_run++;
        if (perf_cycles !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_ready = 1'b1;
            #1;
            tests_run++;
            if ({load_ready, start_valid, f_wr_en} !== 3'b000) begin
                tests_failed++;
                $display("FAIL idle_ignores_start: got %b expected 000", {load_ready, start_valid, f_wr_en});
            end
        end
        @(negedge clk);
        start_ready = 1'b0;
    endtask

    task automatic test_weight_load(input bit with_gap);
        int idx = 0;
        int gap_left = with_gap ? 5 : 0;
        int budget = 0;
        int writes = 0;
        int pushed = -1;
        exp_t e;
        while (idx < 1024 && budget < 4000) begin
            @(negedge clk);
            budget++;
            load_payload = 32'(idx);
            if (with_gap && idx == 300 && gap_left > 0) begin
                init_valid = 1'b0;
                gap_left--;
            end else begin
                init_valid = 1'b1;
            end
            if (init_valid && load_ready && pushed != idx) begin
                exp_q.push_back('{32'(idx), 32'(idx)});
                pushed = idx;
            end
            #1;
            if (w_wr_en) begin
                writes++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL w_unexpected_write: got addr %0d expected no write", w_wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({22'b0, w_wr_addr} !== e.addr || w_wr_data !== e.data) begin
                        tests_failed++;
                        $display("FAIL w_write: got addr %0d data %0h expected addr %0d data %0h",
                                 w_wr_addr, w_wr_data, e.addr, e.data);
                    end
                end
            end
            if (!init_valid) begin
                tests_run++;
                if (w_wr_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL w_gap: got w_wr_en %b expected 0", w_wr_en);
                end
            end
            if (init_valid && load_ready) idx++;
        end
        tests_run++;
        if (writes != 1024 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL w_total: got %0d writes (%0d pending) expected 1024 (0 pending)", writes, exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        init_valid = 1'b0;
        #1;
        tests_run++;
        if ({start_valid, init_ready, load_ready} !== 3'b110) begin
            tests_failed++;
            $display("FAIL w_ready_after_load: got %b expected 110", {start_valid, init_ready, load_ready});
        end
    endtask

    task automatic test_feature_load();
        int b = 0;
        int junk = 0;
        int budget = 0;
        int pause = 0;
        exp_t e;
        while (b < 128 && budget < 1000) begin
            @(negedge clk);
            budget++;
            if (b == 64 && pause < 3) begin
                start_ready = 1'b0;
                pause++;
            end else begin
                start_ready = 1'b1;
            end
            load_payload = load_ready ? feat_beat(b) : (32'hDEAD_0000 | 32'(junk));
            if (load_ready && start_ready) exp_q.push_back('{32'(b), feat_beat(b)});
            #1;
            if (f_wr_en) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL f_unexpected_write: got addr %0d data %h expected no write", f_wr_addr, f_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({25'b0, f_wr_addr} !== e.addr || f_wr_data !== e.data) begin
                        tests_failed++;
                        $display("FAIL f_write: got addr %0d data %h expected addr %0d data %h",
                                 f_wr_addr, f_wr_data, e.addr, e.data);
                    end
                end
            end
            if (!load_ready) junk++;
            if (load_ready && start_ready) b++;
        end
        tests_run++;
        if (b != 128 || junk != 3 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL f_total: got %0d beats %0d ignored %0d pending expected 128 beats 3 ignored 0 pending",
                     b, junk, exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        start_ready = 1'b0;
        load_payload = '0;
        #1;
        tests_run++;
        if (comp_start !== 1'b1 || load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL comp_start_pulse: got comp_start %b load_ready %b expected 1 0", comp_start, load_ready);
        end
    endtask

    // Entered one negedge into the comp_start cycle; comp_done follows 50 cycles after comp_start.
    task automatic test_compute_drain(input int abort_beat);
        int cyc = 0;
        int first_at = -1;
        int beats = 0;
        bit gap = 1'b0;
        logic [31:0] exp;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            init_valid  = (i >= 10 && i < 15);
            start_ready = (i >= 10 && i < 15);
            #1;
            if (i == 0 || i == 12) begin
                tests_run++;
                if ({comp_start, load_ready, init_ready, start_valid, w_wr_en, f_wr_en, r_rd_en} !== 7'b0) begin
                    tests_failed++;
                    $display("FAIL compute_quiet: got %b expected 0000000",
                             {comp_start, load_ready, init_ready, start_valid, w_wr_en, f_wr_en, r_rd_en});
                end
            end
        end
        @(negedge clk);
        comp_done = 1'b1;
        for (int k = 0; k < 128; k++) res_q.push_back(32'(k * 3));
        while (cyc < 200) begin
            @(negedge clk);
            comp_done = 1'b0;
            cyc++;
            #1;
            if (result_valid) begin
                if (first_at < 0) first_at = cyc;
                if (cyc != first_at + beats) gap = 1'b1;
                tests_run++;
                if (res_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL result_extra: got %0d expected no beat", result_payload);
                end else begin
                    exp = res_q.pop_front();
                    if (result_payload !== exp) begin
                        tests_failed++;
                        $display("FAIL result_beat %0d: got %0d expected %0d", beats, result_payload, exp);
                    end
                end
                beats++;
                if (abort_beat >= 0 && beats - 1 == abort_beat) begin
                    rst_n = 1'b0;
                    res_q.delete();
                    return;
                end
            end else if (beats > 0) begin
                break;
            end
        end
        tests_run++;
        if (first_at != 2 || beats != 128 || gap || res_q.size() != 0) begin
            tests_failed++;
            $display("FAIL result_stream: got first %0d beats %0d gap %0d expected first 2 beats 128 gap 0",
                     first_at, beats, gap);
        end
        res_q.delete();
        tests_run++;
        if ({start_valid, result_valid, r_rd_en} !== 3'b100) begin
            tests_failed++;
            $display("FAIL ready_after_drain: got %b expected 100", {start_valid, result_valid, r_rd_en});
        end
    endtask

    task automatic test_back_to_back();
        int w_before = w_wr_total;
        @(negedge clk);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        #1;
        tests_run++;
        if ({r_rd_en, result_valid, start_valid} !== 3'b001) begin
            tests_failed++;
            $display("FAIL stray_comp_done: got %b expected 001", {r_rd_en, result_valid, start_valid});
        end
        test_feature_load();
        test_compute_drain(-1);
        tests_run++;
        if (w_wr_total != w_before) begin
            tests_failed++;
            $display("FAIL no_reload_writes: got %0d weight writes expected %0d", w_wr_total, w_before);
        end
    endtask

    task automatic test_init_priority();
        @(negedge clk);
        init_valid   = 1'b1;
        start_ready  = 1'b1;
        load_payload = 32'h0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({load_ready, start_valid, w_wr_en} !== 3'b101 || w_wr_addr !== 10'd0) begin
            tests_failed++;
            $display("FAIL init_priority: got %b addr %0d expected 101 addr 0",
                     {load_ready, start_valid, w_wr_en}, w_wr_addr);
        end
        init_valid  = 1'b0;
        start_ready = 1'b0;
        test_weight_load(1'b0);
    endtask

    task automatic test_reset_mid_drain();
        test_feature_load();
        test_compute_drain(40);
        @(negedge clk);
        #1;
        tests_run++;
        if ({result_valid, start_valid, r_rd_en, load_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid_drain: got %b expected 0000", {result_valid, start_valid, r_rd_en, load_ready});
        end
`ifdef HOST_IF_PERF_EN
        tests_run++;
        if (perf_cycles !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_drain_perf: got %0d expected 0", perf_cycles);
        end
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_ready = 1'b1;
            #1;
            tests_run++;
            if ({init_ready, load_ready, start_valid, f_wr_en} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL weights_discarded: got %b expected 1000",
                         {init_ready, load_ready, start_valid, f_wr_en});
            end
        end
        @(negedge clk);
        start_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_weight_load(1'b1);
        test_feature_load();
        test_compute_drain(-1);
        test_back_to_back();
        test_init_priority();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
